// File: rtl/timer_pkg.sv
// Shared Timer_A/Timer_B definitions: interrupt-vector codes and read-FSM encoding.
package timer_pkg;

  localparam int CCM_MAX = 7;

  localparam logic [3:0] IV_NONE  = 4'h0;
  localparam logic [3:0] IV_CCR1  = 4'h2;
  localparam logic [3:0] IV_CCR2  = 4'h4;
  localparam logic [3:0] IV_CCR3  = 4'h6;
  localparam logic [3:0] IV_CCR4  = 4'h8;
  localparam logic [3:0] IV_CCR5  = 4'hA;
  localparam logic [3:0] IV_CCR6  = 4'hC;
  localparam logic [3:0] IV_TAIFG = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_CLR  = 2'd2
  } rdState_t;

endpackage

// File: rtl/timer_iv_ctrl_if.sv
// Flag, read and vector signals between the timer core / CPU bus and the IV controller.
interface timer_iv_ctrl_if #(
  parameter int CCM_COUNT = 3
);
  logic                 taifg;
  logic                 taie;
  logic [CCM_COUNT-1:0] ccifg;
  logic [CCM_COUNT-1:0] ccie;
  logic                 iv_rd;
  logic                 int0_ack;
  logic                 dbg_halt;
  logic [3:0]           iv_q;
  logic                 int0;
  logic                 int1;
  logic                 taifg_clr;
  logic [CCM_COUNT-1:0] ccifg_clr;

  modport master (
    output taifg, taie, ccifg, ccie, iv_rd, int0_ack, dbg_halt,
    input  iv_q, int0, int1, taifg_clr, ccifg_clr
  );

  modport slave (
    input  taifg, taie, ccifg, ccie, iv_rd, int0_ack, dbg_halt,
    output iv_q, int0, int1, taifg_clr, ccifg_clr
  );
endinterface

// File: rtl/timer_iv_prio.sv
// Combinational IV priority encoder: lowest enabled CCRn (n>=1) wins, then overflow.
module timer_iv_prio
  import timer_pkg::*;
#(
  parameter int         CCM_COUNT = 3,
  parameter logic [3:0] OVF_IV    = IV_TAIFG
) (
  input  logic [CCM_COUNT-1:0] ccifg,
  input  logic [CCM_COUNT-1:0] ccie,
  input  logic                 taifg,
  input  logic                 taie,
  output logic [3:0]           code
);

  logic [CCM_COUNT-1:0] hits;
  logic [CCM_COUNT-1:0] shifted;
  logic                 unusedCcr0;

  assign hits       = ccifg & ccie;
  // CCR0 has its own vector and never enters TAxIV.
  assign unusedCcr0 = hits[0];

  always_comb begin
    code    = (taifg && taie) ? OVF_IV : IV_NONE;
    shifted = '0;
    for (int n = CCM_COUNT - 1; n >= 1; n--) begin
      shifted = hits >> n;
      if (shifted[0]) code = 4'(2 * n);
    end
  end

endmodule

// File: rtl/timer_iv_ctrl.sv
// TAxIV register with read freeze, clear-on-read pulse generation and CCR0 acknowledge clear.
module timer_iv_ctrl
  import timer_pkg::*;
#(
  parameter int         CCM_COUNT = 3,
  parameter logic [3:0] OVF_IV    = IV_TAIFG,
  parameter bit         DBG_NOCLR = 1'b1
) (
  input  logic      MCLK,
  input  logic      reset_n,
  timer_iv_ctrl_if.slave bus
);

  rdState_t             stateQ, stateD;
  logic                 dbgSeenQ, dbgSeenD;
  logic                 enterClr, clrEn;
  logic [3:0]           cand;
  logic [3:0]           ivQ;
  logic                 int0Q, int1Q;
  logic                 taifgClrQ, readClrOvf;
  logic [CCM_COUNT-1:0] ccifgClrQ, readClrCcr;

  function automatic logic [CCM_COUNT-1:0] ccrClr(input logic [3:0] code);
    logic [CCM_COUNT-1:0] c;
    c = '0;
    for (int n = 1; n < CCM_COUNT; n++)
      if (code == 4'(2 * n) && code != OVF_IV) c = CCM_COUNT'(1) << n;
    return c;
  endfunction

  timer_iv_prio #(.CCM_COUNT(CCM_COUNT), .OVF_IV(OVF_IV)) u_prio (
    .ccifg (bus.ccifg),
    .ccie  (bus.ccie),
    .taifg (bus.taifg),
    .taie  (bus.taie),
    .code  (cand)
  );

  always_comb begin
    stateD   = stateQ;
    dbgSeenD = 1'b0;
    enterClr = 1'b0;
    case (stateQ)
      ST_IDLE: if (bus.iv_rd) begin
        stateD   = ST_HOLD;
        dbgSeenD = bus.dbg_halt;
      end
      ST_HOLD: begin
        dbgSeenD = dbgSeenQ | bus.dbg_halt;
        if (!bus.iv_rd) begin
          stateD   = ST_CLR;
          enterClr = 1'b1;
        end
      end
      ST_CLR:  stateD = ST_IDLE;
      default: stateD = ST_IDLE;
    endcase
    // Clears are registered on the HOLD->CLR edge so the pulse occupies exactly the CLR cycle.
    clrEn      = enterClr && !(DBG_NOCLR && (dbgSeenQ || bus.dbg_halt));
    readClrCcr = clrEn ? ccrClr(ivQ) : '0;
    readClrOvf = clrEn && (ivQ == OVF_IV) && (ivQ != IV_NONE);
  end

  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      stateQ    <= ST_IDLE;
      dbgSeenQ  <= 1'b0;
      ivQ       <= IV_NONE;
      int0Q     <= 1'b0;
      int1Q     <= 1'b0;
      taifgClrQ <= 1'b0;
      ccifgClrQ <= '0;
    end else begin
      stateQ   <= stateD;
      dbgSeenQ <= dbgSeenD;
      // Freeze is exactly "not IDLE": the vector loads on the read's first edge, then holds.
      if (stateQ == ST_IDLE) begin
        ivQ   <= cand;
        int1Q <= (cand != IV_NONE);
      end
      int0Q     <= bus.ccifg[0] & bus.ccie[0];
      taifgClrQ <= readClrOvf;
      ccifgClrQ <= readClrCcr | CCM_COUNT'(bus.int0_ack);
    end
  end

  assign bus.iv_q      = ivQ;
  assign bus.int0      = int0Q;
  assign bus.int1      = int1Q;
  assign bus.taifg_clr = taifgClrQ;
  assign bus.ccifg_clr = ccifgClrQ;

endmodule

// File: tb/tb_timer_iv_ctrl.sv
// Directed table-driven bench for timer_iv_ctrl (CCM_COUNT=3, OVF_IV=14, DBG_NOCLR=1).
module tb_timer_iv_ctrl;

  logic MCLK    = 1'b0;
  logic reset_n = 1'b0;
  always #5 MCLK = ~MCLK;

  timer_iv_ctrl_if #(.CCM_COUNT(3)) bus ();

  timer_iv_ctrl #(.CCM_COUNT(3), .OVF_IV(4'hE), .DBG_NOCLR(1'b1)) dut (
    .MCLK    (MCLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [2:0] cc, ce;
    logic       tf, te, rd, ack, dbg;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [9:0] pk(input logic [3:0] iv, input logic i1, input logic i0,
                                    input logic tc, input logic [2:0] cc);
    return {iv, i1, i0, tc, cc};
  endfunction

  function automatic logic [9:0] outs();
    return {bus.iv_q, bus.int1, bus.int0, bus.taifg_clr, bus.ccifg_clr};
  endfunction

  function automatic void add(input logic [2:0] cc, input logic [2:0] ce, input logic tf,
                              input logic te, input logic rd, input logic ack, input logic dbg,
                              input logic [3:0] iv, input logic i1, input logic i0,
                              input logic tc, input logic [2:0] clr);
    vec_t v;
    v.cc = cc; v.ce = ce; v.tf = tf; v.te = te; v.rd = rd; v.ack = ack; v.dbg = dbg;
    v.exp = pk(iv, i1, i0, tc, clr);
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got iv=%0d int1=%b int0=%b tclr=%b cclr=%b, expected iv=%0d int1=%b int0=%b tclr=%b cclr=%b",
               name, act[9:6], act[5], act[4], act[3], act[2:0],
               exp[9:6], exp[5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic drive(input logic [2:0] cc, input logic [2:0] ce, input logic tf,
                       input logic te, input logic rd, input logic ack, input logic dbg);
    bus.ccifg = cc; bus.ccie = ce; bus.taifg = tf; bus.taie = te;
    bus.iv_rd = rd; bus.int0_ack = ack; bus.dbg_halt = dbg;
  endtask

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  initial begin
    drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    check("reset", outs(), pk(4'd0, 1'b0, 1'b0, 1'b0, 3'b000));

    //   cc      ce     tf te rd ak dbg   iv  i1 i0 tc clr
    // Flags present, then a 3-cycle read of code 2
    add(3'b110, 3'b110, 1, 1, 0, 0, 0,  4'd2,  1, 0, 0, 3'b000);
    add(3'b110, 3'b110, 1, 1, 1, 0, 0,  4'd2,  1, 0, 0, 3'b000);
    add(3'b110, 3'b110, 1, 1, 1, 0, 0,  4'd2,  1, 0, 0, 3'b000);
    add(3'b110, 3'b110, 1, 1, 1, 0, 0,  4'd2,  1, 0, 0, 3'b000);
    add(3'b110, 3'b110, 1, 1, 0, 0, 0,  4'd2,  1, 0, 0, 3'b010);
    add(3'b100, 3'b110, 1, 1, 0, 0, 0,  4'd2,  1, 0, 0, 3'b000);
    add(3'b100, 3'b110, 1, 1, 0, 0, 0,  4'd4,  1, 0, 0, 3'b000);
    // Read under debug halt: no clear
    add(3'b100, 3'b110, 1, 1, 1, 0, 1,  4'd4,  1, 0, 0, 3'b000);
    add(3'b100, 3'b110, 1, 1, 1, 0, 0,  4'd4,  1, 0, 0, 3'b000);
    add(3'b100, 3'b110, 1, 1, 0, 0, 0,  4'd4,  1, 0, 0, 3'b000);
    add(3'b100, 3'b110, 1, 1, 0, 0, 0,  4'd4,  1, 0, 0, 3'b000);
    add(3'b100, 3'b110, 1, 1, 0, 0, 0,  4'd4,  1, 0, 0, 3'b000);
    // Normal read of code 4
    add(3'b100, 3'b110, 1, 1, 1, 0, 0,  4'd4,  1, 0, 0, 3'b000);
    add(3'b100, 3'b110, 1, 1, 0, 0, 0,  4'd4,  1, 0, 0, 3'b100);
    add(3'b000, 3'b110, 1, 1, 0, 0, 0,  4'd4,  1, 0, 0, 3'b000);
    add(3'b000, 3'b110, 1, 1, 0, 0, 0,  4'd14, 1, 0, 0, 3'b000);
    // Overflow-only one-cycle read
    add(3'b000, 3'b110, 1, 1, 1, 0, 0,  4'd14, 1, 0, 0, 3'b000);
    add(3'b000, 3'b110, 1, 1, 0, 0, 0,  4'd14, 1, 0, 1, 3'b000);
    add(3'b000, 3'b110, 0, 1, 0, 0, 0,  4'd14, 1, 0, 0, 3'b000);
    add(3'b000, 3'b110, 0, 1, 0, 0, 0,  4'd0,  0, 0, 0, 3'b000);
    // CCR0 request and ack coinciding with a CLR of code 2
    add(3'b011, 3'b011, 0, 1, 0, 0, 0,  4'd2,  1, 1, 0, 3'b000);
    add(3'b011, 3'b011, 0, 1, 1, 0, 0,  4'd2,  1, 1, 0, 3'b000);
    add(3'b011, 3'b011, 0, 1, 0, 1, 0,  4'd2,  1, 1, 0, 3'b011);
    add(3'b000, 3'b011, 0, 1, 0, 0, 0,  4'd2,  1, 0, 0, 3'b000);
    add(3'b000, 3'b011, 0, 1, 0, 0, 0,  4'd0,  0, 0, 0, 3'b000);
    add(3'b000, 3'b011, 0, 1, 0, 1, 0,  4'd0,  0, 0, 0, 3'b001);
    add(3'b000, 3'b011, 0, 1, 0, 0, 0,  4'd0,  0, 0, 0, 3'b000);
    // IE dropped during HOLD: frozen code still cleared
    add(3'b010, 3'b010, 0, 1, 0, 0, 0,  4'd2,  1, 0, 0, 3'b000);
    add(3'b010, 3'b010, 0, 1, 1, 0, 0,  4'd2,  1, 0, 0, 3'b000);
    add(3'b010, 3'b000, 0, 1, 1, 0, 0,  4'd2,  1, 0, 0, 3'b000);
    add(3'b010, 3'b000, 0, 1, 0, 0, 0,  4'd2,  1, 0, 0, 3'b010);
    add(3'b000, 3'b000, 0, 1, 0, 0, 0,  4'd2,  1, 0, 0, 3'b000);
    add(3'b000, 3'b000, 0, 1, 0, 0, 0,  4'd0,  0, 0, 0, 3'b000);
    // Back-to-back read: reassert in CLR, second read sees refreshed vector
    add(3'b110, 3'b110, 0, 0, 0, 0, 0,  4'd2,  1, 0, 0, 3'b000);
    add(3'b110, 3'b110, 0, 0, 1, 0, 0,  4'd2,  1, 0, 0, 3'b000);
    add(3'b110, 3'b110, 0, 0, 0, 0, 0,  4'd2,  1, 0, 0, 3'b010);
    add(3'b100, 3'b110, 0, 0, 1, 0, 0,  4'd2,  1, 0, 0, 3'b000);
    add(3'b100, 3'b110, 0, 0, 1, 0, 0,  4'd4,  1, 0, 0, 3'b000);
    add(3'b100, 3'b110, 0, 0, 0, 0, 0,  4'd4,  1, 0, 0, 3'b100);
    add(3'b000, 3'b110, 0, 0, 0, 0, 0,  4'd4,  1, 0, 0, 3'b000);
    add(3'b000, 3'b110, 0, 0, 0, 0, 0,  4'd0,  0, 0, 0, 3'b000);

    @(negedge MCLK);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].cc, tbl[i].ce, tbl[i].tf, tbl[i].te, tbl[i].rd, tbl[i].ack, tbl[i].dbg);
      step();
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Reset asserted while the read is held
    drive(3'b010, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("rst_pre", outs(), pk(4'd2, 1'b1, 1'b0, 1'b0, 3'b000));
    bus.iv_rd = 1'b1;
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async", outs(), pk(4'd0, 1'b0, 1'b0, 1'b0, 3'b000));
    bus.iv_rd = 1'b0;
    @(negedge MCLK);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_rel%0d", i), outs(), pk(4'd2, 1'b1, 1'b0, 1'b0, 3'b000));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_iv_ctrl.md
Name: timer_iv_ctrl

Overview:
- Registered interrupt-vector controller for Timer_A/Timer_B class timers with up to 7 capture/compare blocks plus the timer-overflow flag.
- Produces the TAxIV register value and the INT0/INT1 requests to the interrupt unit.
- Generates the one-cycle IFG clear pulses for the read-to-clear and vector-acknowledge paths.
- Adds the following: a registered vector, a vector freeze for the whole CPU read, a clear issued once per read, debug-halt read protection, and a parametrised overflow vector code.

Parameters:
- CCM_COUNT, 3, number of CCM blocks (1..7); CCR0 is always block 0.
- OVF_IV, 4'hE, vector code reported for TAIFG (4'hE for Timer_A, 4'hE or 4'h0E-compatible for Timer_B).
- DBG_NOCLR, 1, when 1 a read during dbg_halt never clears a flag.

Ports:
- MCLK  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- taifg  in  1  timer overflow IFG.
- taie  in  1  overflow IE.
- ccifg  in  CCM_COUNT  CCR IFGs.
- ccie  in  CCM_COUNT  CCR IEs.
- iv_rd  in  1  high while the bus reads TAxIV (MAB match and MR); may last more than one cycle.
- int0_ack  in  1  one-cycle vector-fetch acknowledge for the CCR0 interrupt.
- dbg_halt  in  1  CPU halted by the debugger.
- iv_q  out  4  current TAxIV value (read data).
- int0  out  1  CCR0 interrupt request.
- int1  out  1  shared-vector interrupt request.
- taifg_clr  out  1  one-cycle clear for TAIFG.
- ccifg_clr  out  CCM_COUNT  one-cycle clears for the CCR IFGs.

Behaviour:
- Reset (async, reset_n=0): iv_q=0, int0=0, int1=0, taifg_clr=0, ccifg_clr=0, freeze=0, captured code=0.

Priority encoder (combinational):
- Candidate code = 2*n for the lowest n in 1..CCM_COUNT-1 with ccifg[n]&ccie[n].
- Otherwise OVF_IV if taifg&taie.
- Otherwise 0.
- CCR0 never appears in the vector.

Vector register:
- When freeze=0, iv_q <= candidate every MCLK edge, so iv_q lags the flags by 1 cycle.
- int1 <= (candidate != 0), same cycle as iv_q.
- int0 <= ccifg[0]&ccie[0], registered with 1-cycle latency.

Read state machine (states IDLE, HOLD, CLR):
- IDLE: on iv_rd=1, go to HOLD and set freeze=1. iv_q keeps the value it had on that edge, so the bus sees a stable word.
- HOLD: stay while iv_rd=1. On iv_rd=0, go to CLR.
- CLR: for exactly one cycle, pulse the clear matching the frozen code. Code 2..12 pulses ccifg_clr[code/2]; code OVF_IV pulses taifg_clr; code 0 pulses nothing. Then set freeze=0 and return to IDLE.
- iv_rd reasserting in CLR is accepted from IDLE on the next cycle; a back-to-back read sees the refreshed vector.
- dbg_halt=1 at any cycle of the read with DBG_NOCLR=1 suppresses the CLR pulse. The FSM still passes through CLR.
- Frozen code whose CCM index >= CCM_COUNT (never produced, defensive): no pulse.

CCR0 acknowledge:
- int0_ack=1 pulses ccifg_clr[0] on the next cycle, independent of the read FSM.
- Both clears may pulse in the same cycle (different bits OR together).

Boundary conditions:
- A new IFG during HOLD is not visible in iv_q until freeze drops. It is not lost, because the source flag persists.
- A flag cleared by software during HOLD still gets its clear pulse; this is harmless.
- IE dropped during HOLD: the frozen code is still cleared.
- reset_n low mid-read aborts the FSM to IDLE with no pulse.
- All clear outputs are exactly one cycle wide.

Decomposition:
- Shared package timer_pkg: IV code constants (IV_NONE=0, IV_CCR1=2 … IV_CCR6=12, IV_TAIFG=14), the read-FSM state encoding, and the CCM_COUNT max (7).
- Sub-module timer_iv_prio: pure combinational priority encoder (ccifg, ccie, taifg, taie -> code). It is reused by the future Timer_B wrapper.

Test Plan:
- Reset then flags: ccifg=3'b110, ccie=3'b110, taifg=1, taie=1 -> iv_q=2 one cycle later, int1=1, int0=0.
- Read 3 cycles with iv_q=2 while ccifg[2] still set -> iv_q stays 2 during the read; ccifg_clr=3'b010 for exactly one cycle after iv_rd falls; after the clear, iv_q=4.
- Overflow only: taifg=1, taie=1, read one cycle -> iv_q=14, taifg_clr single pulse; iv_q=0 after the flag drops.
- dbg_halt=1 during a read of iv_q=4 -> no ccifg_clr pulse; iv_q returns to 4 afterwards.
- ccifg[0]=1, ccie[0]=1 -> int0=1 after 1 cycle; int0_ack pulse coinciding with a CLR of code 2 -> ccifg_clr=3'b011 in one cycle.
- reset_n asserted in HOLD -> all outputs 0 immediately; no clear pulse after release.
